io_bus_ctrl: RTL and testbench

//  Memory-mapped I/O controller between the CPU write/read strobes and the peripherals.

---
 rtl/io_bus_ctrl_pkg.sv | 20 ++
 rtl/io_bus_ctrl_if.sv | 28 ++
 rtl/io_bus_ctrl_sync_fifo.sv | 61 ++++++
 rtl/io_bus_ctrl.sv | 117 +++++++++++
 tb/tb_io_bus_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_ctrl_pkg.sv
// io_bus_ctrl_pkg: shared constants and types for the memory-mapped I/O controller.
//   addr_t       - CPU register address (word index)
//   ADDR_*       - register map
//   STAT_*       - bit positions inside the STAT register
package io_bus_ctrl_pkg;

  typedef logic [3:0] addr_t;

  localparam addr_t ADDR_LED  = 4'h0;
  localparam addr_t ADDR_TXD  = 4'h1;
  localparam addr_t ADDR_STAT = 4'h2;
  localparam addr_t ADDR_ERRC = 4'h3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 8;
  localparam int STAT_ERR     = 16;

endpackage

// File: rtl/io_bus_ctrl_if.sv
// io_bus_ctrl_if: CPU-side register bus of io_bus_ctrl.
//   write_i/read_i  strobes, one transfer per cycle
//   addr_i/wdata_i  register address and write data
//   stall_o         write not accepted this cycle (CPU holds request)
//   rdata_o/rvalid_o registered read data and its one-cycle valid pulse
// Modports: master (CPU), slave (controller).
interface io_bus_ctrl_if;
  import io_bus_ctrl_pkg::*;

  logic        write_i;
  logic        read_i;
  addr_t       addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;

  modport master (
    output write_i, read_i, addr_i, wdata_i,
    input  stall_o, rdata_o, rvalid_o
  );

  modport slave (
    input  write_i, read_i, addr_i, wdata_i,
    output stall_o, rdata_o, rvalid_o
  );

endinterface

// File: rtl/io_bus_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk_i, rst_i (async, active-high)
//   push_i/din_i   write side; ignored when full
//   pop_i/dout_o   read side; dout_o is the head entry; ignored when empty
//   full_o, empty_o, count_o ($clog2(DEPTH)+1 bits)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign count_o = cnt;
  assign dout_o  = mem[rd_ptr];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is not reset: contents are only observable through valid entries.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped I/O controller between CPU strobes and peripherals.
//   clk_i, rst_i (async, active-high)
//   bus            CPU register bus (io_bus_ctrl_if.slave)
//   led_o          LED register
//   uart_valid_o/uart_data_o/uart_ready_i  TX byte stream out of the queue
//   err_o          sticky flag: access to an unmapped address
module io_bus_ctrl
  import io_bus_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LED_W      = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  io_bus_ctrl_if.slave     bus,
  output logic [LED_W-1:0] led_o,
  output logic             uart_valid_o,
  output logic [7:0]       uart_data_o,
  input  logic             uart_ready_i,
  output logic             err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          is_led, is_txd, is_stat, is_errc, is_unmapped;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push, pop;
  logic [31:0]   rd_mux;
  logic [31:0]   rdata_q;
  logic          rvalid_q;
  logic          err_q;
  logic [LED_W-1:0] led_q;
  logic          unused_wdata;

  assign is_led      = (bus.addr_i == ADDR_LED);
  assign is_txd      = (bus.addr_i == ADDR_TXD);
  assign is_stat     = (bus.addr_i == ADDR_STAT);
  assign is_errc     = (bus.addr_i == ADDR_ERRC);
  assign is_unmapped = !(is_led || is_txd || is_stat || is_errc);

  // Stall depends only on the registered full flag; a same-cycle pop
  // does not let the held write through.
  assign bus.stall_o = bus.write_i && is_txd && fifo_full;
  assign push        = bus.write_i && is_txd && !fifo_full;
  assign pop         = !fifo_empty && uart_ready_i;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (bus.wdata_i[7:0]),
    .pop_i   (pop),
    .dout_o  (uart_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign uart_valid_o = !fifo_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q <= '0;
    end else if (bus.write_i && is_led) begin
      led_q <= bus.wdata_i[LED_W-1:0];
    end
  end

  assign led_o = led_q;

  // Clear has priority over a same-cycle unmapped access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (bus.write_i && is_errc) begin
      err_q <= 1'b0;
    end else if ((bus.write_i || bus.read_i) && is_unmapped) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  // Read mux samples pre-edge state, so STAT shows the queue before any
  // same-cycle push or pop.
  always_comb begin
    rd_mux = '0;
    if (is_led) begin
      rd_mux[LED_W-1:0] = led_q;
    end else if (is_stat) begin
      rd_mux[STAT_EMPTY] = fifo_empty;
      rd_mux[STAT_FULL]  = fifo_full;
      rd_mux[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
      rd_mux[STAT_ERR]   = err_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus.read_i;
      if (bus.read_i) rdata_q <= rd_mux;
    end
  end

  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

  assign unused_wdata = ^bus.wdata_i[31:8];

endmodule

// File: tb/tb_io_bus_ctrl.sv
module tb_io_bus_ctrl;
  import io_bus_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] led_o;
  logic       uart_valid_o;
  logic [7:0] uart_data_o;
  logic       uart_ready_i;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  io_bus_ctrl_if bus ();

  io_bus_ctrl #(
    .FIFO_DEPTH (8),
    .LED_W      (6)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .led_o        (led_o),
    .uart_valid_o (uart_valid_o),
    .uart_data_o  (uart_data_o),
    .uart_ready_i (uart_ready_i),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input addr_t a);
    bus.read_i = 1'b1;
    bus.addr_i = a;
    tick();
    bus.read_i = 1'b0;
  endtask

  task automatic do_write(input addr_t a, input logic [31:0] d);
    bus.write_i = 1'b1;
    bus.addr_i  = a;
    bus.wdata_i = d;
    tick();
    bus.write_i = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    bus.write_i  = 1'b0;
    bus.read_i   = 1'b0;
    bus.addr_i   = '0;
    bus.wdata_i  = '0;
    uart_ready_i = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_led",    32'(led_o), 32'h0);
    check("rst_valid",  32'(uart_valid_o), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
    check("rst_rdata",  bus.rdata_o, 32'h0);
    check("rst_err",    32'(err_o), 32'h0);
    rst_i = 1'b0;
    tick();

    // LED write / read
    do_write(ADDR_LED, 32'h0000_002A);
    check("led_wr", 32'(led_o), 32'h2A);
    do_read(ADDR_LED);
    check("led_rd_valid", 32'(bus.rvalid_o), 32'h1);
    check("led_rd_data",  bus.rdata_o, 32'h2A);
    tick();
    check("rvalid_pulse", 32'(bus.rvalid_o), 32'h0);
    check("rdata_hold",   bus.rdata_o, 32'h2A);
    // read + write same register same cycle: read sees old value, masked write
    bus.write_i = 1'b1;
    bus.read_i  = 1'b1;
    bus.addr_i  = ADDR_LED;
    bus.wdata_i = 32'hFFFF_FFD5;
    tick();
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    check("rw_led_rdata", bus.rdata_o, 32'h2A);
    check("rw_led_mask",  32'(led_o), 32'h15);

    // fill the queue with ready low
    for (int i = 0; i < 8; i++) begin
      bus.write_i = 1'b1;
      bus.addr_i  = ADDR_TXD;
      bus.wdata_i = 32'h10 + 32'(i);
      #1;
      check("fill_nostall", 32'(bus.stall_o), 32'h0);
      tick();
    end
    bus.write_i = 1'b0;
    do_read(ADDR_STAT);
    check("stat_full", bus.rdata_o, 32'h0000_0802);
    bus.write_i = 1'b1;
    bus.addr_i  = ADDR_TXD;
    bus.wdata_i = 32'h18;
    #1;
    check("stall_full", 32'(bus.stall_o), 32'h1);
    tick();
    tick();
    check("stall_hold", 32'(bus.stall_o), 32'h1);
    check("stall_count", 32'(dut.fifo_count), 32'h8);
    uart_ready_i = 1'b1;
    #1;
    check("stall_nobypass", 32'(bus.stall_o), 32'h1);
    check("head_10", 32'(uart_data_o), 32'h10);
    tick();
    check("stall_release", 32'(bus.stall_o), 32'h0);
    check("head_11", 32'(uart_data_o), 32'h11);
    tick();
    bus.write_i = 1'b0;
    for (int b = 8'h12; b <= 8'h18; b++) begin
      check("drain_valid", 32'(uart_valid_o), 32'h1);
      check("drain_data",  32'(uart_data_o), 32'(b));
      tick();
    end
    check("drained_valid", 32'(uart_valid_o), 32'h0);
    do_read(ADDR_STAT);
    check("stat_empty", bus.rdata_o, 32'h0000_0001);

    // half-full streaming: push and pop every cycle
    uart_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) do_write(ADDR_TXD, 32'h20 + 32'(i));
    uart_ready_i = 1'b1;
    for (int j = 0; j < 8; j++) begin
      bus.write_i = 1'b1;
      bus.addr_i  = ADDR_TXD;
      bus.wdata_i = 32'h24 + 32'(j);
      #1;
      check("stream_nostall", 32'(bus.stall_o), 32'h0);
      check("stream_head",    32'(uart_data_o), 32'h20 + 32'(j));
      tick();
      check("stream_count",   32'(dut.fifo_count), 32'h4);
    end
    bus.write_i  = 1'b0;
    uart_ready_i = 1'b0;
    do_read(ADDR_STAT);
    check("stat_half", bus.rdata_o, 32'h0000_0400);
    uart_ready_i = 1'b1;
    for (int b = 8'h28; b <= 8'h2B; b++) begin
      check("stream_tail", 32'(uart_data_o), 32'(b));
      tick();
    end
    check("stream_empty", 32'(uart_valid_o), 32'h0);
    uart_ready_i = 1'b0;

    // error flag
    do_write(4'h7, 32'h0);
    check("err_set", 32'(err_o), 32'h1);
    do_read(ADDR_STAT);
    check("stat_err", bus.rdata_o, 32'h0001_0001);
    do_write(ADDR_STAT, 32'hFFFF_FFFF);
    check("stat_wr_keeps_err", 32'(err_o), 32'h1);
    do_write(ADDR_ERRC, 32'h0);
    check("err_clr", 32'(err_o), 32'h0);
    do_write(ADDR_STAT, 32'hFFFF_FFFF);
    check("stat_wr_noerr", 32'(err_o), 32'h0);
    do_read(4'h9);
    check("unmapped_rvalid", 32'(bus.rvalid_o), 32'h1);
    check("unmapped_rdata",  bus.rdata_o, 32'h0);
    check("unmapped_rd_err", 32'(err_o), 32'h1);
    do_write(ADDR_ERRC, 32'h1234);
    check("err_clr2", 32'(err_o), 32'h0);

    // STAT read concurrent with a pop reflects pre-pop state
    do_write(ADDR_TXD, 32'h55);
    uart_ready_i = 1'b1;
    do_read(ADDR_STAT);
    uart_ready_i = 1'b0;
    check("stat_prepop", bus.rdata_o, 32'h0000_0100);
    do_read(ADDR_STAT);
    check("stat_postpop", bus.rdata_o, 32'h0000_0001);

    // async reset mid-transfer
    for (int i = 0; i < 3; i++) do_write(ADDR_TXD, 32'h30 + 32'(i));
    uart_ready_i = 1'b1;
    #1;
    check("pre_rst_valid", 32'(uart_valid_o), 32'h1);
    check("pre_rst_led",   32'(led_o), 32'h15);
    rst_i = 1'b1;
    #1;
    check("async_rst_valid", 32'(uart_valid_o), 32'h0);
    check("async_rst_led",   32'(led_o), 32'h0);
    check("async_rst_count", 32'(dut.fifo_count), 32'h0);
    uart_ready_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    do_read(ADDR_STAT);
    check("post_rst_stat", bus.rdata_o, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
